// File: rtl/vga_timing_gen.sv
// Two-mode VGA raster timing generator. The mode can change only at a frame boundary.
// Every output is registered and decodes the counter state from one pixel strobe earlier.
module vga_timing_gen #(
  parameter int XW       = 11,
  parameter int YW       = 10,
  parameter int A_HACT   = 800,
  parameter int A_HFP    = 56,
  parameter int A_HSYNC  = 120,
  parameter int A_HBP    = 64,
  parameter int A_VACT   = 600,
  parameter int A_VFP    = 37,
  parameter int A_VSYNC  = 6,
  parameter int A_VBP    = 23,
  parameter int B_HACT   = 640,
  parameter int B_HFP    = 16,
  parameter int B_HSYNC  = 96,
  parameter int B_HBP    = 48,
  parameter int B_VACT   = 480,
  parameter int B_VFP    = 10,
  parameter int B_VSYNC  = 2,
  parameter int B_VBP    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          PixelEn,
  input  logic          ModeSel,
  output logic          blank_n,
  output logic          sync_n,
  output logic          hSync_n,
  output logic          vSync_n,
  output logic [XW-1:0] nextX,
  output logic [YW-1:0] nextY,
  output logic          LineStart,
  output logic          FrameStart,
  output logic          ModeActive
);

  localparam int A_HTOT = A_HACT + A_HFP + A_HSYNC + A_HBP;
  localparam int A_VTOT = A_VACT + A_VFP + A_VSYNC + A_VBP;
  localparam int B_HTOT = B_HACT + B_HFP + B_HSYNC + B_HBP;
  localparam int B_VTOT = B_VACT + B_VFP + B_VSYNC + B_VBP;

  // Region bounds are held as inclusive last indices, so each one fits in the counter width
  // whenever HTOT-1 and VTOT-1 fit.
  localparam logic [XW-1:0] A_H_ACT_LAST  = XW'(A_HACT - 1);
  localparam logic [XW-1:0] A_H_SYNC_BEG  = XW'(A_HACT + A_HFP);
  localparam logic [XW-1:0] A_H_SYNC_LAST = XW'(A_HACT + A_HFP + A_HSYNC - 1);
  localparam logic [XW-1:0] A_H_LAST      = XW'(A_HTOT - 1);
  localparam logic [YW-1:0] A_V_ACT_LAST  = YW'(A_VACT - 1);
  localparam logic [YW-1:0] A_V_SYNC_BEG  = YW'(A_VACT + A_VFP);
  localparam logic [YW-1:0] A_V_SYNC_LAST = YW'(A_VACT + A_VFP + A_VSYNC - 1);
  localparam logic [YW-1:0] A_V_LAST      = YW'(A_VTOT - 1);

  localparam logic [XW-1:0] B_H_ACT_LAST  = XW'(B_HACT - 1);
  localparam logic [XW-1:0] B_H_SYNC_BEG  = XW'(B_HACT + B_HFP);
  localparam logic [XW-1:0] B_H_SYNC_LAST = XW'(B_HACT + B_HFP + B_HSYNC - 1);
  localparam logic [XW-1:0] B_H_LAST      = XW'(B_HTOT - 1);
  localparam logic [YW-1:0] B_V_ACT_LAST  = YW'(B_VACT - 1);
  localparam logic [YW-1:0] B_V_SYNC_BEG  = YW'(B_VACT + B_VFP);
  localparam logic [YW-1:0] B_V_SYNC_LAST = YW'(B_VACT + B_VFP + B_VSYNC - 1);
  localparam logic [YW-1:0] B_V_LAST      = YW'(B_VTOT - 1);

  if ((A_HTOT - 1) >= 2**XW || (B_HTOT - 1) >= 2**XW) begin : g_xw_too_narrow
    $fatal(1, "vga_timing_gen: HTOT-1 does not fit in XW bits");
  end
  if ((A_VTOT - 1) >= 2**YW || (B_VTOT - 1) >= 2**YW) begin : g_yw_too_narrow
    $fatal(1, "vga_timing_gen: VTOT-1 does not fit in YW bits");
  end

  logic [XW-1:0] h_count;
  logic [YW-1:0] v_count;
  logic          mode_q;

  logic [XW-1:0] h_act_last_q, h_sync_beg_q, h_sync_last_q, h_last_q;
  logic [YW-1:0] v_act_last_q, v_sync_beg_q, v_sync_last_q, v_last_q;

  logic [XW-1:0] sel_h_act_last, sel_h_sync_beg, sel_h_sync_last, sel_h_last;
  logic [YW-1:0] sel_v_act_last, sel_v_sync_beg, sel_v_sync_last, sel_v_last;

  logic h_wrap, v_wrap, frame_wrap, load_mode;
  logic h_active, v_active, active;
  logic h_in_sync, v_in_sync;

  // ModeSel feeds only the timing-constant registers. It never reaches the decode logic directly.
  // NOTE: each output gets a default first so the mode mux can never infer a latch.
  always_comb begin
    sel_h_act_last  = A_H_ACT_LAST;
    sel_h_sync_beg  = A_H_SYNC_BEG;
    sel_h_sync_last = A_H_SYNC_LAST;
    sel_h_last      = A_H_LAST;
    sel_v_act_last  = A_V_ACT_LAST;
    sel_v_sync_beg  = A_V_SYNC_BEG;
    sel_v_sync_last = A_V_SYNC_LAST;
    sel_v_last      = A_V_LAST;
    if (ModeSel) begin
      sel_h_act_last  = B_H_ACT_LAST;
      sel_h_sync_beg  = B_H_SYNC_BEG;
      sel_h_sync_last = B_H_SYNC_LAST;
      sel_h_last      = B_H_LAST;
      sel_v_act_last  = B_V_ACT_LAST;
      sel_v_sync_beg  = B_V_SYNC_BEG;
      sel_v_sync_last = B_V_SYNC_LAST;
      sel_v_last      = B_V_LAST;
    end
  end

  assign h_wrap     = (h_count == h_last_q);
  assign v_wrap     = (v_count == v_last_q);
  assign frame_wrap = h_wrap && v_wrap;
  assign load_mode  = Reset || (PixelEn && frame_wrap);

  assign h_active  = (h_count <= h_act_last_q);
  assign v_active  = (v_count <= v_act_last_q);
  assign active    = h_active && v_active;
  assign h_in_sync = (h_count >= h_sync_beg_q) && (h_count <= h_sync_last_q);
  assign v_in_sync = (v_count >= v_sync_beg_q) && (v_count <= v_sync_last_q);

  // NOTE: all state uses non-blocking assignments so that every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      h_count <= '0;
      v_count <= '0;
      mode_q  <= ModeSel;
    end else if (PixelEn) begin
      if (h_wrap) begin
        h_count <= '0;
        if (v_wrap) begin
          v_count <= '0;
          mode_q  <= ModeSel;
        end else begin
          v_count <= v_count + YW'(1);
        end
      end else begin
        h_count <= h_count + XW'(1);
      end
    end
  end

  // The timing constants are latched together with the mode, so they stay fixed for the whole frame.
  always_ff @(posedge Clock) begin
    if (load_mode) begin
      h_act_last_q  <= sel_h_act_last;
      h_sync_beg_q  <= sel_h_sync_beg;
      h_sync_last_q <= sel_h_sync_last;
      h_last_q      <= sel_h_last;
      v_act_last_q  <= sel_v_act_last;
      v_sync_beg_q  <= sel_v_sync_beg;
      v_sync_last_q <= sel_v_sync_last;
      v_last_q      <= sel_v_last;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      blank_n    <= 1'b0;
      sync_n     <= 1'b1;
      hSync_n    <= ~HSYNC_POL;
      vSync_n    <= ~VSYNC_POL;
      nextX      <= '0;
      nextY      <= '0;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
    end else if (PixelEn) begin
      blank_n    <= active;
      sync_n     <= ~(h_in_sync || v_in_sync);
      hSync_n    <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
      vSync_n    <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
      nextX      <= active ? h_count : '0;
      nextY      <= active ? v_count : '0;
      LineStart  <= (h_count == '0);
      FrameStart <= (h_count == '0) && (v_count == '0);
    end else begin
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
    end
  end

  assign ModeActive = mode_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: the driver pushes the expected result of each edge, and the monitor pops and compares it.
// It uses two scaled-down instances (both sync polarities) and one default-size instance for line-0 timing.
module tb_vga_timing_gen;

  typedef struct {
    int hact, hfp, hsync, hbp, vact, vfp, vsync, vbp;
  } cfg_t;

  typedef struct {
    bit blank_n, sync_n, hs_in, vs_in, ls, fs, mode;
    int x, y;
  } exp_t;

  typedef struct {
    exp_t s;
    exp_t b;
  } exp_set_t;

  logic Clock = 1'b0;
  logic Reset, PixelEn, ModeSel;

  logic       s_blank_n, s_sync_n, s_hSync_n, s_vSync_n, s_LineStart, s_FrameStart, s_ModeActive;
  logic [3:0] s_nextX;
  logic [2:0] s_nextY;
  logic       p_blank_n, p_sync_n, p_hSync_n, p_vSync_n, p_LineStart, p_FrameStart, p_ModeActive;
  logic [3:0] p_nextX;
  logic [2:0] p_nextY;
  logic       b_blank_n, b_sync_n, b_hSync_n, b_vSync_n, b_LineStart, b_FrameStart, b_ModeActive;
  logic [10:0] b_nextX;
  logic [9:0]  b_nextY;

  always #5 Clock = ~Clock;

  // Small timings: mode A is 15x8 (frame of 120 pixels) and mode B is 10x6 (frame of 60 pixels).
  vga_timing_gen #(
    .XW(4), .YW(3),
    .A_HACT(8), .A_HFP(2), .A_HSYNC(3), .A_HBP(2), .A_VACT(4), .A_VFP(1), .A_VSYNC(2), .A_VBP(1),
    .B_HACT(6), .B_HFP(1), .B_HSYNC(2), .B_HBP(1), .B_VACT(3), .B_VFP(1), .B_VSYNC(1), .B_VBP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) u_small (
    .Clock(Clock), .Reset(Reset), .PixelEn(PixelEn), .ModeSel(ModeSel),
    .blank_n(s_blank_n), .sync_n(s_sync_n), .hSync_n(s_hSync_n), .vSync_n(s_vSync_n),
    .nextX(s_nextX), .nextY(s_nextY), .LineStart(s_LineStart), .FrameStart(s_FrameStart),
    .ModeActive(s_ModeActive)
  );

  vga_timing_gen #(
    .XW(4), .YW(3),
    .A_HACT(8), .A_HFP(2), .A_HSYNC(3), .A_HBP(2), .A_VACT(4), .A_VFP(1), .A_VSYNC(2), .A_VBP(1),
    .B_HACT(6), .B_HFP(1), .B_HSYNC(2), .B_HBP(1), .B_VACT(3), .B_VFP(1), .B_VSYNC(1), .B_VBP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_small_pol (
    .Clock(Clock), .Reset(Reset), .PixelEn(PixelEn), .ModeSel(ModeSel),
    .blank_n(p_blank_n), .sync_n(p_sync_n), .hSync_n(p_hSync_n), .vSync_n(p_vSync_n),
    .nextX(p_nextX), .nextY(p_nextY), .LineStart(p_LineStart), .FrameStart(p_FrameStart),
    .ModeActive(p_ModeActive)
  );

  vga_timing_gen u_big (
    .Clock(Clock), .Reset(Reset), .PixelEn(PixelEn), .ModeSel(ModeSel),
    .blank_n(b_blank_n), .sync_n(b_sync_n), .hSync_n(b_hSync_n), .vSync_n(b_vSync_n),
    .nextX(b_nextX), .nextY(b_nextY), .LineStart(b_LineStart), .FrameStart(b_FrameStart),
    .ModeActive(b_ModeActive)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  cfg_t sa, sb, ba, bb;
  int   s_h, s_v, b_h, b_v;
  bit   s_m, b_m;
  exp_t e_s, e_b;
  exp_set_t exp_q[$];

  // Reference raster: it produces what one edge should present, then advances the position.
  task automatic model_step(input cfg_t ca, input cfg_t cb, input bit rst, input bit pe, input bit ms,
                            inout int h, inout int v, inout bit m, inout exp_t e);
    cfg_t c;
    if (rst) begin
      h = 0; v = 0; m = ms;
      e.blank_n = 1'b0; e.sync_n = 1'b1; e.hs_in = 1'b0; e.vs_in = 1'b0;
      e.x = 0; e.y = 0; e.ls = 1'b0; e.fs = 1'b0; e.mode = ms;
    end else if (pe) begin
      c = m ? cb : ca;
      e.blank_n = (h < c.hact) && (v < c.vact);
      e.x       = e.blank_n ? h : 0;
      e.y       = e.blank_n ? v : 0;
      e.hs_in   = (h >= c.hact + c.hfp) && (h < c.hact + c.hfp + c.hsync);
      e.vs_in   = (v >= c.vact + c.vfp) && (v < c.vact + c.vfp + c.vsync);
      e.sync_n  = !(e.hs_in || e.vs_in);
      e.ls      = (h == 0);
      e.fs      = (h == 0) && (v == 0);
      if (h == c.hact + c.hfp + c.hsync + c.hbp - 1) begin
        h = 0;
        if (v == c.vact + c.vfp + c.vsync + c.vbp - 1) begin
          v = 0;
          m = ms;
        end else begin
          v++;
        end
      end else begin
        h++;
      end
      e.mode = m;
    end else begin
      e.ls = 1'b0;
      e.fs = 1'b0;
    end
  endtask

  task automatic step(input bit rst, input bit pe, input bit ms);
    exp_set_t es;
    @(negedge Clock);
    Reset = rst; PixelEn = pe; ModeSel = ms;
    model_step(sa, sb, rst, pe, ms, s_h, s_v, s_m, e_s);
    model_step(ba, bb, rst, pe, ms, b_h, b_v, b_m, e_b);
    es.s = e_s;
    es.b = e_b;
    exp_q.push_back(es);
  endtask

  task automatic cmp_inst(input string tag, input exp_t e, input bit hpol, input bit vpol,
                          input logic bl, input logic sy, input logic hs, input logic vs,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic ls, input logic fs, input logic md);
    check({tag, ".blank_n"},    32'(bl), 32'(e.blank_n));
    check({tag, ".sync_n"},     32'(sy), 32'(e.sync_n));
    check({tag, ".hSync_n"},    32'(hs), 32'(e.hs_in ? hpol : !hpol));
    check({tag, ".vSync_n"},    32'(vs), 32'(e.vs_in ? vpol : !vpol));
    check({tag, ".nextX"},      x, 32'(e.x));
    check({tag, ".nextY"},      y, 32'(e.y));
    check({tag, ".LineStart"},  32'(ls), 32'(e.ls));
    check({tag, ".FrameStart"}, 32'(fs), 32'(e.fs));
    check({tag, ".ModeActive"}, 32'(md), 32'(e.mode));
  endtask

  int   fs_cnt = 0;
  bit   fs_valid = 1'b0, fs_mode = 1'b0;
  int   n_period_a = 0, n_period_b = 0;
  bit   after_reset = 1'b0;
  int   b_pix = 0, hs_fall_at = 0;
  logic b_prev_hs = 1'b1, b_prev_bl = 1'b0;
  logic [10:0] b_prev_x = '0;
  bit   hs_fall_done = 1'b0, hs_rise_done = 1'b0, bl_done = 1'b0;

  // Monitor process
  initial begin
    exp_set_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp_inst("small", e.s, 1'b0, 1'b0, s_blank_n, s_sync_n, s_hSync_n, s_vSync_n,
                 32'(s_nextX), 32'(s_nextY), s_LineStart, s_FrameStart, s_ModeActive);
        cmp_inst("pol", e.s, 1'b1, 1'b1, p_blank_n, p_sync_n, p_hSync_n, p_vSync_n,
                 32'(p_nextX), 32'(p_nextY), p_LineStart, p_FrameStart, p_ModeActive);
        cmp_inst("big", e.b, 1'b0, 1'b0, b_blank_n, b_sync_n, b_hSync_n, b_vSync_n,
                 32'(b_nextX), 32'(b_nextY), b_LineStart, b_FrameStart, b_ModeActive);

        if (Reset) begin
          fs_valid    = 1'b0;
          after_reset = 1'b1;
        end else if (PixelEn) begin
          if (after_reset) begin
            check("post_reset_FrameStart", 32'(s_FrameStart), 32'd1);
            check("post_reset_blank_n", 32'(s_blank_n), 32'd1);
            after_reset = 1'b0;
          end
          fs_cnt++;
          if (s_FrameStart) begin
            check("fs_nextY", 32'(s_nextY), 32'd0);
            check("fs_nextX", 32'(s_nextX), 32'd0);
            if (fs_valid) begin
              if (fs_mode) begin
                check("frame_period_B", 32'(fs_cnt), 32'd60);
                n_period_b++;
              end else begin
                check("frame_period_A", 32'(fs_cnt), 32'd120);
                n_period_a++;
              end
            end
            fs_cnt   = 0;
            fs_valid = 1'b1;
            fs_mode  = s_ModeActive;
          end

          if (b_LineStart) b_pix = 0;
          else b_pix++;
          if (b_prev_hs && !b_hSync_n && !hs_fall_done) begin
            check("big_hsync_start", 32'(b_pix), 32'd856);
            hs_fall_at   = b_pix;
            hs_fall_done = 1'b1;
          end
          if (!b_prev_hs && b_hSync_n && hs_fall_done && !hs_rise_done) begin
            check("big_hsync_width", 32'(b_pix - hs_fall_at), 32'd120);
            hs_rise_done = 1'b1;
          end
          if (b_prev_bl && !b_blank_n && !bl_done) begin
            check("big_blank_fall_x", 32'(b_pix), 32'd800);
            check("big_last_active_x", 32'(b_prev_x), 32'd799);
            bl_done = 1'b1;
          end
        end
        b_prev_hs = b_hSync_n;
        b_prev_bl = b_blank_n;
        b_prev_x  = b_nextX;
      end
    end
  end

  // Driver process
  initial begin
    sa = '{8, 2, 3, 2, 4, 1, 2, 1};
    sb = '{6, 1, 2, 1, 3, 1, 1, 1};
    ba = '{800, 56, 120, 64, 600, 37, 6, 23};
    bb = '{640, 16, 96, 48, 480, 10, 2, 33};
    Reset = 1'b1; PixelEn = 1'b0; ModeSel = 1'b0;

    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    // Run continuously. This covers the full first line of the large instance and many small frames.
    repeat (1100) step(1'b0, 1'b1, 1'b0);
    // Strobe every second clock.
    for (int i = 0; i < 300; i++) step(1'b0, i[0], 1'b0);
    // Change ModeSel mid-frame, with a short glitch back to A, then return to A.
    repeat (37) step(1'b0, 1'b1, 1'b0);
    repeat (200) step(1'b0, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    repeat (200) step(1'b0, 1'b1, 1'b1);
    repeat (200) step(1'b0, 1'b1, 1'b0);
    repeat (23) step(1'b0, 1'b1, 1'b1);
    // One-clock reset mid-frame, which latches mode B directly.
    step(1'b1, 1'b1, 1'b1);
    repeat (150) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 400; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    @(posedge Clock);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("seen_period_A", 32'(n_period_a != 0), 32'd1);
    check("seen_period_B", 32'(n_period_b != 0), 32'd1);
    check("seen_big_hsync", 32'(hs_fall_done && hs_rise_done), 32'd1);
    check("seen_big_blank_fall", 32'(bl_done), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
 XW, 11, width of nextX and horizontal counter
 YW, 10, width of nextY and vertical counter
 A_HACT/A_HFP/A_HSYNC/A_HBP, 800/56/120/64, mode A horizontal active/front porch/sync/back porch (pixels)
 A_VACT/A_VFP/A_VSYNC/A_VBP, 600/37/6/23, mode A vertical timings (lines)
 B_HACT/B_HFP/B_HSYNC/B_HBP, 640/16/96/48, mode B horizontal timings
 B_VACT/B_VFP/B_VSYNC/B_VBP, 480/10/2/33, mode B vertical timings
 HSYNC_POL, 0, 0 means hSync_n is low during sync; 1 means it is high during sync
 VSYNC_POL, 0, same rule for vSync_n
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
 Clock       in   1   sole clock, rising edge
 Reset       in   1   synchronous, active-high
 PixelEn     in   1   pixel strobe; timing advances only when high
 ModeSel     in   1   requested mode (0 = A, 1 = B), applied at frame boundary only
 blank_n     out  1   high in the active region
 sync_n      out  1   low while in horizontal or vertical sync (always active-low)
 hSync_n     out  1   horizontal sync, polarity per HSYNC_POL
 vSync_n     out  1   vertical sync, polarity per VSYNC_POL
 nextX       out  XW  pixel column in the active region, else 0
 nextY       out  YW  pixel row in the active region, else 0
 LineStart   out  1   one-Clock pulse when hCount==0
 FrameStart  out  1   one-Clock pulse when hCount==0 and vCount==0
 ModeActive  out  1   mode currently being generated

Function
REQ-003 The block SHALL hold internal counters hCount (XW bits) and vCount (YW bits); HTOT=HACT+HFP+HSYNC+HBP and VTOT=VACT+VFP+VSYNC+VBP of the active mode (A: 1040/666; B: 800/525).
REQ-004 On a Clock edge with PixelEn=1, hCount SHALL increment, and at HTOT-1 it SHALL wrap to 0; vCount SHALL increment only on that wrap, and at VTOT-1 (on the same wrap) it SHALL go to 0.
REQ-005 With PixelEn=0 the counters and all outputs SHALL hold, except LineStart and FrameStart, which SHALL be 0.
REQ-006 All outputs SHALL be registered and updated only on PixelEn=1 edges, each one decoding the counter values before that edge's increment (one PixelEn-cycle latency).
REQ-007 Active region: hCount<HACT and vCount<VACT; there blank_n=1, nextX=hCount and nextY=vCount; otherwise blank_n=0 and nextX=nextY=0.
REQ-008 Horizontal sync region: HACT+HFP <= hCount < HACT+HFP+HSYNC; vertical sync region: VACT+VFP <= vCount < VACT+VFP+VSYNC.
REQ-009 hSync_n SHALL be asserted in the horizontal sync region using the HSYNC_POL level; vSync_n follows the same rule with VSYNC_POL.
REQ-010 sync_n SHALL be 0 when hCount or vCount is in its sync region, else 1, regardless of the polarity parameters.
REQ-011 LineStart and FrameStart SHALL pulse for exactly one Clock, on the PixelEn edge that decodes the qualifying count.
REQ-012 ModeSel SHALL be sampled only on the PixelEn edge where hCount=HTOT-1 and vCount=VTOT-1; the new mode takes effect from count (0,0); a mid-frame ModeSel change SHALL NOT alter the current frame.
REQ-013 ModeActive SHALL change on the same edge the counters wrap to (0,0) under the new mode.
REQ-014 The block SHALL perform all comparisons against the active mode's timing values, registered as constants when the mode is latched, with no combinational path from ModeSel to the outputs.
REQ-015 Widths: every HTOT-1 SHALL fit in XW bits and every VTOT-1 in YW bits; if a parameter set violates this, elaboration SHALL fail by assertion.

Reset
REQ-016 With Reset=1 on a Clock edge, regardless of PixelEn, the block SHALL set hCount=0, vCount=0, mode=ModeSel, blank_n=0, sync_n=1, hSync_n and vSync_n to their inactive levels, nextX=0, nextY=0, LineStart=0 and FrameStart=0.
REQ-017 Reset asserted mid-frame SHALL abort the frame; the first PixelEn edge after release SHALL decode (0,0), giving blank_n=1, LineStart=1 and FrameStart=1.

Verification
REQ-018 Mode A, PixelEn=1 constantly, one full frame -> hSync_n low for 120 clocks starting at hCount 856, vSync_n low for lines 637..642, and 1040x666 clocks between FrameStart pulses.
REQ-019 Mode A, PixelEn high every 2nd clock -> the same counts measured in PixelEn cycles, LineStart 1 Clock wide, and the outputs steady on idle clocks.
REQ-020 ModeSel 0->1 at line 300 of mode A -> the current frame completes at 1040x666; the next frame is 800x525 with hSync low over hCount 656..751; ModeActive toggles at wrap.
REQ-021 HSYNC_POL=1, VSYNC_POL=1 -> hSync_n and vSync_n high in sync, while sync_n remains low in sync.
REQ-022 Reset for 1 clock at (hCount 500, vCount 200) -> the next PixelEn edge gives nextX=0, nextY=0, blank_n=1 and FrameStart=1.
REQ-023 Boundary: hCount 799->800 -> blank_n falls and nextX becomes 0; vCount wrap 665->0 -> FrameStart pulses with nextY=0.
